// File: rtl/onchip_mem_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_arb_pkg
//  Description : Shared types and default widths for the on-chip RAM
//                round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package onchip_arb_pkg;

    localparam int c_num_masters_def = 2;
    localparam int c_addr_w_def      = 13;
    localparam int c_data_w_def      = 32;
    localparam int c_be_w_def        = c_data_w_def / 8;

    // Index width for a master number; never narrower than one bit.
    function automatic int mst_w_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int c_mst_w = mst_w_of(c_num_masters_def);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/onchip_mem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_mem_rr_arbiter_if
//  Description : Bundle of the per-master Avalon-MM request/response signals
//                and the single RAM port driven by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface onchip_mem_rr_arbiter_if
    import onchip_arb_pkg::*;
#(
    parameter int NUM_MASTERS = c_num_masters_def,
    parameter int ADDR_W      = c_addr_w_def,
    parameter int DATA_W      = c_data_w_def,
    parameter int BE_W        = c_be_w_def
);

    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS*BE_W-1:0]   m_byteenable;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]        m_lock;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [NUM_MASTERS-1:0]        m_readdatavalid;
    logic [DATA_W-1:0]             m_readdata;

    logic [ADDR_W-1:0]             mem_address;
    logic [BE_W-1:0]               mem_byteenable;
    logic                          mem_chipselect;
    logic                          mem_write;
    logic [DATA_W-1:0]             mem_writedata;
    logic                          mem_clken;
    logic [DATA_W-1:0]             mem_readdata;

    logic                          err_proto;

    // Arbiter side: takes master requests and RAM read data.
    modport slave (
        input  m_address, m_byteenable, m_read, m_write, m_writedata, m_lock,
        input  mem_readdata,
        output m_waitrequest, m_readdatavalid, m_readdata,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken, err_proto
    );

    // Environment side: drives master requests and RAM read data.
    modport master (
        output m_address, m_byteenable, m_read, m_write, m_writedata, m_lock,
        output mem_readdata,
        input  m_waitrequest, m_readdatavalid, m_readdata,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken, err_proto
    );

endinterface
`default_nettype wire

// File: rtl/onchip_mem_rr_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant
//  Description : Pure combinational round-robin pick. Searches the request
//                vector starting at i_ptr, wrapping to 0, and returns a
//                one-hot grant plus its index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant
    import onchip_arb_pkg::*;
#(
    parameter int N     = c_num_masters_def,
    parameter int IDX_W = mst_w_of(c_num_masters_def)
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N-1:0]     o_gnt,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_valid
);

    logic [N-1:0] w_upper;
    logic [N-1:0] w_pick;

    // Prefer requests at or above the pointer; otherwise wrap to the lowest.
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < N; i++) begin
            w_upper[i] = i_req[i] && (i >= int'(i_ptr));
        end
        w_pick  = (|w_upper) ? w_upper : i_req;
        o_gnt   = '0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_idx    = IDX_W'(i);
            end
        end
        o_valid = |i_req;
    end

endmodule
`default_nettype wire

// File: rtl/onchip_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : onchip_mem_rr_arbiter
//  Description : Round-robin arbiter placing NUM_MASTERS Avalon-MM masters
//                onto the single port of the on-chip RAM. One access per
//                cycle, 1-cycle read return, locked (atomic) sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_rr_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int NUM_MASTERS = c_num_masters_def,
    parameter int ADDR_W      = c_addr_w_def,
    parameter int DATA_W      = c_data_w_def,
    parameter int BE_W        = c_be_w_def
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    onchip_mem_rr_arbiter_if.slave bus
);

    localparam int c_idx_w = mst_w_of(NUM_MASTERS);
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(NUM_MASTERS - 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [c_idx_w-1:0]    r_rr_ptr;
    logic [c_idx_w-1:0]    w_rr_ptr_nxt;
    logic [c_idx_w-1:0]    r_owner;
    logic [c_idx_w-1:0]    w_owner_nxt;
    logic                  r_rd_pend;
    logic [c_idx_w-1:0]    r_rd_owner;
    logic                  r_err_proto;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_elig;
    logic [NUM_MASTERS-1:0] w_req_elig;
    logic [NUM_MASTERS-1:0] w_gnt;
    logic [c_idx_w-1:0]     w_gidx;
    logic                   w_gvalid;
    logic                   w_gwrite;
    logic                   w_gread;
    logic                   w_glock;
    logic                   w_proto_bad;

    logic [ADDR_W-1:0]      w_mem_address;
    logic [BE_W-1:0]        w_mem_be;
    logic [DATA_W-1:0]      w_mem_wdata;

    function automatic logic [c_idx_w-1:0] f_next(input logic [c_idx_w-1:0] idx);
        return (idx == c_last) ? c_idx_w'(0) : idx + c_idx_w'(1);
    endfunction

    // While locked only the owner competes; reset_n masks every grant so the
    // RAM sees no access and all masters stall during reset.
    assign w_req       = bus.m_read | bus.m_write;
    assign w_elig      = (r_state == LOCKED) ? (NUM_MASTERS'(1) << r_owner) : '1;
    assign w_req_elig  = w_req & w_elig & {NUM_MASTERS{reset_n}};
    assign w_proto_bad = |(bus.m_read & bus.m_write);

    rr_grant #(
        .N     (NUM_MASTERS),
        .IDX_W (c_idx_w)
    ) u_rr_grant (
        .i_req   (w_req_elig),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    // Read+write together counts as a write, so it never produces a response.
    assign w_gwrite = |(w_gnt & bus.m_write);
    assign w_gread  = |(w_gnt & bus.m_read & ~bus.m_write);
    assign w_glock  = |(w_gnt & bus.m_lock);

    // Steer the granted master's request fields onto the RAM port.
    always_comb begin
        w_mem_address = '0;
        w_mem_be      = '0;
        w_mem_wdata   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_gnt[i]) begin
                w_mem_address = bus.m_address[i*ADDR_W +: ADDR_W];
                w_mem_be      = bus.m_byteenable[i*BE_W +: BE_W];
                w_mem_wdata   = bus.m_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.mem_address     = w_mem_address;
    assign bus.mem_byteenable  = w_mem_be;
    assign bus.mem_writedata   = w_mem_wdata;
    assign bus.mem_chipselect  = w_gvalid;
    assign bus.mem_write       = w_gwrite;
    assign bus.mem_clken       = 1'b1;
    assign bus.m_waitrequest   = ~w_gnt;
    assign bus.m_readdatavalid = NUM_MASTERS'(r_rd_pend) << r_rd_owner;
    assign bus.m_readdata      = bus.mem_readdata;
    assign bus.err_proto       = r_err_proto;

    // Next-state: lock entry on a locked grant, release on the owner's
    // unlocked transfer; the pointer advances past whoever just finished.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        case (r_state)
            ARB: begin
                if (w_gvalid) begin
                    if (w_glock) begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_gidx;
                    end else begin
                        w_rr_ptr_nxt = f_next(w_gidx);
                    end
                end
            end
            LOCKED: begin
                if (w_gvalid && !w_glock) begin
                    w_state_nxt  = ARB;
                    w_rr_ptr_nxt = f_next(r_owner);
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // State, pointer, read-return tracking and sticky protocol error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ARB;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_owner  <= '0;
            r_err_proto <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_rd_pend   <= w_gread;
            r_rd_owner  <= w_gidx;
            r_err_proto <= r_err_proto | w_proto_bad;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onchip_mem_rr_arbiter
//  Description : Directed bench for the on-chip RAM round-robin arbiter with
//                a RAM stub, a transaction-level reference model checked on
//                every cycle, and hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_rr_arbiter;
    import onchip_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    onchip_mem_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus ();

    onchip_mem_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- RAM stub: 8192x32, 1-cycle registered read ----------
    logic [DW-1:0] ram [0:8191];
    logic [DW-1:0] ram_q = '0;
    assign bus.mem_readdata = ram_q;

    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken) begin
            if (bus.mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] = bus.mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[bus.mem_address];
            end
        end
    end

    // ---------------- comparison helper ----------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ------------------------------------
    logic [DW-1:0] mdl_mem [0:8191];
    int            m_ptr, m_owner, m_pend_idx;
    bit            m_locked, m_pend, m_err;
    logic [DW-1:0] m_pend_data;

    always @(negedge clk) begin : p_model
        logic [N-1:0]  req, exp_wait, exp_rdv;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
        int            g, cand;
        if (!reset_n) begin
            chk("rst_wait", bus.m_waitrequest, {N{1'b1}});
            chk("rst_rdv", bus.m_readdatavalid, '0);
            chk("rst_cs", bus.mem_chipselect, 0);
            chk("rst_mwr", bus.mem_write, 0);
            chk("rst_err", bus.err_proto, 0);
            m_ptr = 0; m_owner = 0; m_locked = 0; m_pend = 0; m_err = 0;
        end else begin
            req = bus.m_read | bus.m_write;
            g = -1;
            for (int k = 0; k < N; k++) begin
                cand = (m_ptr + k) % N;
                if (g < 0 && req[cand] && (!m_locked || cand == m_owner)) g = cand;
            end
            exp_wait = '1;
            if (g >= 0) exp_wait[g] = 1'b0;
            exp_rdv = '0;
            if (m_pend) exp_rdv[m_pend_idx] = 1'b1;
            chk("m_wait", bus.m_waitrequest, exp_wait);
            chk("m_cs", bus.mem_chipselect, (g >= 0));
            chk("m_clken", bus.mem_clken, 1);
            chk("m_rdv", bus.m_readdatavalid, exp_rdv);
            chk("m_err", bus.err_proto, m_err);
            if (m_pend) chk("m_rdata", bus.m_readdata, m_pend_data);
            m_pend = 0;
            if (g >= 0) begin
                a  = bus.m_address[g*AW +: AW];
                be = bus.m_byteenable[g*BW +: BW];
                wd = bus.m_writedata[g*DW +: DW];
                chk("m_mwr", bus.mem_write, bus.m_write[g]);
                chk("m_addr", bus.mem_address, a);
                if (bus.m_write[g]) begin
                    chk("m_be", bus.mem_byteenable, be);
                    chk("m_wdata", bus.mem_writedata, wd);
                    for (int b = 0; b < BW; b++)
                        if (be[b]) mdl_mem[a][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    m_pend      = 1;
                    m_pend_idx  = g;
                    m_pend_data = mdl_mem[a];
                end
                if (!m_locked) begin
                    if (bus.m_lock[g]) begin
                        m_locked = 1;
                        m_owner  = g;
                    end else begin
                        m_ptr = (g + 1) % N;
                    end
                end else if (!bus.m_lock[g]) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
            if (|(bus.m_read & bus.m_write)) m_err = 1;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic set_in(input logic [N-1:0] rd, wr, lk,
                          input logic [AW-1:0] a0, a1,
                          input logic [DW-1:0] d0, d1,
                          input logic [BW-1:0] be0, be1);
        bus.m_read       = rd;
        bus.m_write      = wr;
        bus.m_lock       = lk;
        bus.m_address    = {a1, a0};
        bus.m_writedata  = {d1, d0};
        bus.m_byteenable = {be1, be0};
    endtask

    task automatic step(input logic [N-1:0] rd, wr, lk,
                        input logic [AW-1:0] a0, a1,
                        input logic [DW-1:0] d0, d1,
                        input logic [BW-1:0] be0, be1);
        @(posedge clk); #1;
        set_in(rd, wr, lk, a0, a1, d0, d1, be0, be1);
        @(negedge clk);
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence -----------------------------------
    initial begin : p_stim
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = '0;
            mdl_mem[i] = '0;
        end
        ram[16]     = 32'hDEADBEEF;
        mdl_mem[16] = 32'hDEADBEEF;

        // Reset with both masters requesting: nobody may be granted.
        set_in(2'b11, 2'b00, 2'b00, 13'h0010, 13'h0010, '0, '0, 4'hF, 4'hF);
        @(negedge clk); @(negedge clk);
        chk("reset_wait", bus.m_waitrequest, 2'b11);
        chk("reset_cs", bus.mem_chipselect, 0);
        chk("reset_rdv", bus.m_readdatavalid, 2'b00);
        chk("reset_err", bus.err_proto, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        set_in(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        @(negedge clk);

        // Single read by m0 from 0x0010.
        step(2'b01, 2'b00, 2'b00, 13'h0010, '0, '0, '0, 4'hF, '0);
        chk("t1_wait", bus.m_waitrequest, 2'b10);
        chk("t1_addr", bus.mem_address, 13'h0010);
        idle();
        chk("t1_rdv", bus.m_readdatavalid, 2'b01);
        chk("t1_rdata", bus.m_readdata, 32'hDEADBEEF);

        // Byte write by m1 at the top address, then read it back.
        step(2'b00, 2'b10, 2'b00, '0, 13'h1FFF, '0, 32'h11223344, '0, 4'b0010);
        chk("t3_wait", bus.m_waitrequest, 2'b01);
        chk("t3_mwr", bus.mem_write, 1);
        step(2'b10, 2'b00, 2'b00, '0, 13'h1FFF, '0, '0, '0, 4'hF);
        chk("t3_rwait", bus.m_waitrequest, 2'b01);
        idle();
        chk("t3_rdv", bus.m_readdatavalid, 2'b10);
        chk("t3_rdata", bus.m_readdata, 32'h00003300);

        // Contention: both masters write continuously, grants alternate.
        for (int k = 0; k < 4; k++) begin
            step(2'b00, 2'b11, 2'b00,
                 13'(32'h100 + (k + 1) / 2), 13'(32'h200 + k / 2),
                 32'hA0000100 + (k + 1) / 2, 32'hB0000200 + k / 2, 4'hF, 4'hF);
            chk("t2_wait", bus.m_waitrequest, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        step(2'b01, 2'b00, 2'b00, 13'h0101, '0, '0, '0, 4'hF, '0);
        step(2'b10, 2'b00, 2'b00, '0, 13'h0201, '0, '0, '0, 4'hF);
        chk("t2_rdata0", bus.m_readdata, 32'hA0000101);
        idle();
        chk("t2_rdata1", bus.m_readdata, 32'hB0000201);

        // Locked sequence by m0 with an idle gap; m1 reads throughout.
        step(2'b10, 2'b01, 2'b01, 13'h0300, 13'h0010, 32'h1, '0, 4'hF, 4'hF);
        chk("t4_c1", bus.m_waitrequest, 2'b10);
        step(2'b10, 2'b00, 2'b00, '0, 13'h0010, '0, '0, '0, 4'hF);
        chk("t4_gap", bus.m_waitrequest, 2'b11);
        step(2'b10, 2'b01, 2'b01, 13'h0301, 13'h0010, 32'h2, '0, 4'hF, 4'hF);
        chk("t4_c3", bus.m_waitrequest, 2'b10);
        step(2'b10, 2'b01, 2'b01, 13'h0302, 13'h0010, 32'h3, '0, 4'hF, 4'hF);
        chk("t4_c4", bus.m_waitrequest, 2'b10);
        step(2'b10, 2'b01, 2'b00, 13'h0303, 13'h0010, 32'h4, '0, 4'hF, 4'hF);
        chk("t4_unlock", bus.m_waitrequest, 2'b10);
        step(2'b10, 2'b00, 2'b00, '0, 13'h0010, '0, '0, '0, 4'hF);
        chk("t4_m1", bus.m_waitrequest, 2'b01);
        idle();
        chk("t4_rdata", bus.m_readdata, 32'hDEADBEEF);

        // Reset right after an m0 read grant: the response must vanish.
        step(2'b01, 2'b00, 2'b00, 13'h0010, '0, '0, '0, 4'hF, '0);
        chk("t5_grant", bus.m_waitrequest, 2'b10);
        @(posedge clk); #1;
        reset_n = 1'b0;
        set_in(2'b11, 2'b00, 2'b00, 13'h0010, 13'h1FFF, '0, '0, 4'hF, 4'hF);
        @(negedge clk);
        chk("t5_rdv", bus.m_readdatavalid, 2'b00);
        chk("t5_wait", bus.m_waitrequest, 2'b11);
        chk("t5_mwr", bus.mem_write, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5_first", bus.m_waitrequest, 2'b10);
        step(2'b10, 2'b00, 2'b00, '0, 13'h1FFF, '0, '0, '0, 4'hF);
        chk("t5_second", bus.m_waitrequest, 2'b01);
        chk("t5_rdata0", bus.m_readdata, 32'hDEADBEEF);
        idle();
        chk("t5_rdata1", bus.m_readdata, 32'h00003300);

        // Read and write together from m1: performed as a write, error sticks.
        step(2'b10, 2'b10, 2'b00, '0, 13'h0020, '0, 32'hCAFEF00D, '0, 4'hF);
        chk("t6_mwr", bus.mem_write, 1);
        chk("t6_err0", bus.err_proto, 0);
        step(2'b01, 2'b00, 2'b00, 13'h0020, '0, '0, '0, 4'hF, '0);
        chk("t6_err1", bus.err_proto, 1);
        chk("t6_nordv", bus.m_readdatavalid, 2'b00);
        idle();
        chk("t6_rdata", bus.m_readdata, 32'hCAFEF00D);
        idle(); idle();
        chk("t6_sticky", bus.err_proto, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst", bus.err_proto, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(); idle();
        chk("t6_after", bus.err_proto, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
